data_bus_initiator: RTL and testbench

Initiator for the Ibex-style data bus (req/gnt/rvalid): turns simple load/store commands into one or two word-aligned bus transactions, with byte enables, write-data rotation, read-data extraction and sign/zero extension. It drives data memory responders standalone in bench traffic generation, with one transaction outstanding at a time. It handles misaligned accesses by splitting them, and bounds every transaction with a timeout.

---
 rtl/data_bus_pkg.sv | 58 +++++
 rtl/data_bus_rdata_align.sv | 33 +++
 rtl/data_bus_initiator.sv | 215 +++++++++++++++++++++
 tb/tb_data_bus_initiator.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_bus_pkg.sv
`default_nettype none
// ============================================================================
// data_bus_pkg: shared types and lane helpers for the data bus initiator
// Revision: 1.0
// ============================================================================
package data_bus_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE    = 2'b00,
    SIZE_HALF    = 2'b01,
    SIZE_WORD    = 2'b10,
    SIZE_ILLEGAL = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ1  = 3'd1,
    ST_WAIT1 = 3'd2,
    ST_REQ2  = 3'd3,
    ST_WAIT2 = 3'd4,
    ST_RESP  = 3'd5
  } state_e;

  // Low nibble is the first word's byte enables, high nibble the second word's.
  function automatic logic [7:0] be_shift(input logic [1:0] size, input logic [1:0] off);
    logic [7:0] mask;
    case (size)
      SIZE_BYTE: mask = 8'b0000_0001;
      SIZE_HALF: mask = 8'b0000_0011;
      default:   mask = 8'b0000_1111;
    endcase
    be_shift = mask << off;
  endfunction

  function automatic logic [31:0] wdata_rotate(input logic [31:0] data, input logic [1:0] off);
    logic [31:0] rot;
    case (off)
      2'd0:    rot = data;
      2'd1:    rot = {data[23:0], data[31:24]};
      2'd2:    rot = {data[15:0], data[31:16]};
      default: rot = {data[7:0], data[31:8]};
    endcase
    wdata_rotate = rot;
  endfunction

  function automatic logic [31:0] extend(input logic [31:0] data, input logic [1:0] size,
                                         input logic is_signed);
    logic [31:0] ext;
    case (size)
      SIZE_BYTE: ext = {{24{is_signed & data[7]}}, data[7:0]};
      SIZE_HALF: ext = {{16{is_signed & data[15]}}, data[15:0]};
      default:   ext = data;
    endcase
    extend = ext;
  endfunction

endpackage
`default_nettype wire

// File: rtl/data_bus_rdata_align.sv
`default_nettype none
// ============================================================================
// data_bus_rdata_align: extracts and extends load data from one or two words
// Revision: 1.0
// ============================================================================
module data_bus_rdata_align
  import data_bus_pkg::*;
(
  input  logic [31:0] part1_rdata,
  // The top byte of the second word can never land in a 32-bit result.
  input  logic [23:0] part2_rdata,
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        is_signed,
  output logic [31:0] result
);

  logic [31:0] w_shifted;

  always_comb begin
    w_shifted = part1_rdata;
    case (off)
      2'd0:    w_shifted = part1_rdata;
      2'd1:    w_shifted = {part2_rdata[7:0],  part1_rdata[31:8]};
      2'd2:    w_shifted = {part2_rdata[15:0], part1_rdata[31:16]};
      default: w_shifted = {part2_rdata[23:0], part1_rdata[31:24]};
    endcase
  end

  assign result = extend(w_shifted, size, is_signed);

endmodule
`default_nettype wire

// File: rtl/data_bus_initiator.sv
`default_nettype none
// ============================================================================
// data_bus_initiator: load/store commands to req/gnt/rvalid bus, split on misalignment
// Revision: 1.0
// ============================================================================
module data_bus_initiator
  import data_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter bit          WRITE_RSP      = 1'b0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_we_i,
  input  logic [1:0]  cmd_size_i,
  input  logic        cmd_signed_i,
  input  logic [31:0] cmd_addr_i,
  input  logic [31:0] cmd_wdata_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic        data_req_o,
  input  logic        data_gnt_i,
  input  logic        data_rvalid_i,
  output logic        data_we_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_addr_o,
  output logic [31:0] data_wdata_o,
  input  logic [31:0] data_rdata_i,
  input  logic        data_err_i
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  state_e           r_state;
  state_e           w_state_next;
  logic             r_we;
  logic [1:0]       r_size;
  logic             r_signed;
  logic [1:0]       r_off;
  logic [3:0]       r_be_hi;
  logic [31:0]      r_rdata1;
  logic [CNT_W-1:0] r_cnt;

  logic        w_accept;
  logic        w_legal;
  logic [7:0]  w_shift;
  logic        w_need2;
  logic        w_expired;
  logic        w_finish;
  logic        w_fin_err;
  logic        w_to_req2;
  logic [31:0] w_part1;
  logic [31:0] w_load_data;

  assign cmd_ready_o = (r_state == ST_IDLE);
  assign data_req_o  = (r_state == ST_REQ1) || (r_state == ST_REQ2);
  assign w_accept    = cmd_valid_i && (r_state == ST_IDLE);
  assign w_legal     = (cmd_size_i != SIZE_ILLEGAL);
  assign w_shift     = be_shift(cmd_size_i, cmd_addr_i[1:0]);
  assign w_need2     = |r_be_hi;
  assign w_expired   = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    w_state_next = r_state;
    w_finish     = 1'b0;
    w_fin_err    = 1'b0;
    w_to_req2    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (cmd_valid_i) begin
          if (!w_legal) begin
            w_state_next = ST_RESP;
            w_finish     = 1'b1;
            w_fin_err    = 1'b1;
          end else begin
            w_state_next = ST_REQ1;
          end
        end
      end
      ST_REQ1, ST_REQ2: begin
        if (data_gnt_i) begin
          if (!r_we || WRITE_RSP) begin
            if (r_state == ST_REQ1) w_state_next = ST_WAIT1;
            else                    w_state_next = ST_WAIT2;
          end else if ((r_state == ST_REQ1) && w_need2) begin
            w_state_next = ST_REQ2;
            w_to_req2    = 1'b1;
          end else begin
            w_state_next = ST_RESP;
            w_finish     = 1'b1;
          end
        end else if (w_expired) begin
          w_state_next = ST_RESP;
          w_finish     = 1'b1;
          w_fin_err    = 1'b1;
        end
      end
      ST_WAIT1: begin
        if (data_rvalid_i) begin
          if (data_err_i) begin
            w_state_next = ST_RESP;
            w_finish     = 1'b1;
            w_fin_err    = 1'b1;
          end else if (w_need2) begin
            w_state_next = ST_REQ2;
            w_to_req2    = 1'b1;
          end else begin
            w_state_next = ST_RESP;
            w_finish     = 1'b1;
          end
        end else if (w_expired) begin
          w_state_next = ST_RESP;
          w_finish     = 1'b1;
          w_fin_err    = 1'b1;
        end
      end
      ST_WAIT2: begin
        if (data_rvalid_i) begin
          w_state_next = ST_RESP;
          w_finish     = 1'b1;
          w_fin_err    = data_err_i;
        end else if (w_expired) begin
          w_state_next = ST_RESP;
          w_finish     = 1'b1;
          w_fin_err    = 1'b1;
        end
      end
      ST_RESP: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= ST_IDLE;
    else         r_state <= w_state_next;
  end

  // Per-part budget: restarts whenever a REQ state is freshly entered.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt <= '0;
    end else if (((w_state_next == ST_REQ1) || (w_state_next == ST_REQ2)) &&
                 (w_state_next != r_state)) begin
      r_cnt <= '0;
    end else if (r_state != ST_IDLE && r_state != ST_RESP) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_we     <= 1'b0;
      r_size   <= 2'b00;
      r_signed <= 1'b0;
      r_off    <= 2'b00;
      r_be_hi  <= 4'b0000;
      r_rdata1 <= '0;
    end else begin
      if (w_accept) begin
        r_we     <= cmd_we_i;
        r_size   <= cmd_size_i;
        r_signed <= cmd_signed_i;
        r_off    <= cmd_addr_i[1:0];
        r_be_hi  <= w_shift[7:4];
      end
      if ((r_state == ST_WAIT1) && data_rvalid_i) r_rdata1 <= data_rdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_we_o    <= 1'b0;
      data_be_o    <= 4'b0000;
      data_addr_o  <= '0;
      data_wdata_o <= '0;
    end else if (w_accept && w_legal) begin
      data_we_o    <= cmd_we_i;
      data_be_o    <= w_shift[3:0];
      data_addr_o  <= {cmd_addr_i[31:2], 2'b00};
      data_wdata_o <= wdata_rotate(cmd_wdata_i, cmd_addr_i[1:0]);
    end else if (w_to_req2) begin
      data_be_o    <= r_be_hi;
      data_addr_o  <= data_addr_o + 32'd4;
    end
  end

  // On the final WAIT cycle the current bus word is still on data_rdata_i.
  assign w_part1 = (r_state == ST_WAIT1) ? data_rdata_i : r_rdata1;

  data_bus_rdata_align u_rdata_align (
    .part1_rdata (w_part1),
    .part2_rdata (data_rdata_i[23:0]),
    .off         (r_off),
    .size        (r_size),
    .is_signed   (r_signed),
    .result      (w_load_data)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_valid_o <= 1'b0;
      rsp_err_o   <= 1'b0;
      rsp_rdata_o <= '0;
    end else begin
      rsp_valid_o <= w_finish;
      rsp_err_o   <= w_fin_err;
      rsp_rdata_o <= (w_finish && !w_fin_err && !r_we) ? w_load_data : '0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_data_bus_initiator.sv
`default_nettype none
// ============================================================================
// tb_data_bus_initiator: directed and random load/store traffic against a byte-level memory model
// Revision: 1.0
// ============================================================================
module tb_data_bus_initiator;

  localparam int TO = 16;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic        cmd_we_i;
  logic [1:0]  cmd_size_i;
  logic        cmd_signed_i;
  logic [31:0] cmd_addr_i;
  logic [31:0] cmd_wdata_i;
  logic        rsp_valid_o;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic        data_req_o;
  logic        data_gnt_i;
  logic        data_rvalid_i;
  logic        data_we_o;
  logic [3:0]  data_be_o;
  logic [31:0] data_addr_o;
  logic [31:0] data_wdata_o;
  logic [31:0] data_rdata_i;
  logic        data_err_i;

  always #5 clk_i = ~clk_i;

  data_bus_initiator #(.TIMEOUT_CYCLES(TO), .WRITE_RSP(1'b0)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
    .cmd_size_i(cmd_size_i), .cmd_signed_i(cmd_signed_i), .cmd_addr_i(cmd_addr_i),
    .cmd_wdata_i(cmd_wdata_i), .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o),
    .rsp_err_o(rsp_err_o), .data_req_o(data_req_o), .data_gnt_i(data_gnt_i),
    .data_rvalid_i(data_rvalid_i), .data_we_o(data_we_o), .data_be_o(data_be_o),
    .data_addr_o(data_addr_o), .data_wdata_o(data_wdata_o), .data_rdata_i(data_rdata_i),
    .data_err_i(data_err_i)
  );

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Responder word memory and the reference byte memory share one power-on pattern.
  bit [31:0] rmem [bit [31:0]];
  bit [7:0]  refm [bit [31:0]];

  function automatic bit [31:0] word_init(input bit [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic bit [31:0] rd_word(input bit [31:0] a);
    if (rmem.exists(a)) return rmem[a];
    return word_init(a);
  endfunction

  function automatic bit [7:0] ref_byte(input bit [31:0] a);
    bit [31:0] w;
    if (refm.exists(a)) return refm[a];
    w = word_init({a[31:2], 2'b00});
    return w[8*a[1:0] +: 8];
  endfunction

  bit        zero_wait = 1'b1;
  bit        block_gnt = 1'b0;
  bit        err_next  = 1'b0;
  bit        no_rsp    = 1'b0;
  bit        pend_rsp  = 1'b0;
  bit [31:0] pend_rdata;
  bit        pend_err;
  int        rsp_delay = 0;
  int        gnt_wait  = 0;
  int        req_cycles = 0;
  bit [31:0] q_addr[$];
  bit [3:0]  q_be[$];
  bit [31:0] q_wdata[$];
  bit        q_we[$];

  initial begin
    bit [31:0] w;
    data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_rdata_i = '0; data_err_i = 1'b0;
    forever begin
      @(negedge clk_i);
      data_rvalid_i = 1'b0;
      data_err_i    = 1'b0;
      data_rdata_i  = $urandom;
      data_gnt_i    = 1'b0;
      if (!rst_ni) begin
        pend_rsp = 1'b0;
        gnt_wait = 0;
      end else begin
        if (pend_rsp && !no_rsp) begin
          if (rsp_delay == 0) begin
            data_rvalid_i = 1'b1;
            data_rdata_i  = pend_rdata;
            data_err_i    = pend_err;
            pend_rsp      = 1'b0;
          end else begin
            rsp_delay--;
          end
        end
        if (data_req_o) begin
          req_cycles++;
          if (!block_gnt) begin
            if (gnt_wait == 0) begin
              data_gnt_i = 1'b1;
              q_addr.push_back(data_addr_o);
              q_be.push_back(data_be_o);
              q_wdata.push_back(data_wdata_o);
              q_we.push_back(data_we_o);
              if (data_we_o) begin
                w = rd_word(data_addr_o);
                for (int j = 0; j < 4; j++)
                  if (data_be_o[j]) w[8*j +: 8] = data_wdata_o[8*j +: 8];
                rmem[data_addr_o] = w;
              end else begin
                pend_rsp   = 1'b1;
                pend_rdata = rd_word(data_addr_o);
                pend_err   = err_next;
                err_next   = 1'b0;
                rsp_delay  = zero_wait ? 0 : int'($urandom_range(0, 2));
              end
              gnt_wait = zero_wait ? 0 : int'($urandom_range(0, 3));
            end else begin
              gnt_wait--;
            end
          end
        end
      end
    end
  end

  task automatic run_check(input bit we, input bit [1:0] size, input bit sgn,
                           input bit [31:0] addr, input bit [31:0] wdata, input bit exp_fail,
                           output bit [31:0] rdata, output int lat);
    bit        err, got, req_at_rsp;
    int        n, off, parts, g;
    bit [31:0] base, exp_rd, exp_w, mask;
    bit [3:0]  exp_be;
    q_addr.delete(); q_be.delete(); q_wdata.delete(); q_we.delete();
    req_cycles = 0;
    @(negedge clk_i);
    cmd_valid_i = 1'b1; cmd_we_i = we; cmd_size_i = size; cmd_signed_i = sgn;
    cmd_addr_i = addr; cmd_wdata_i = wdata;
    @(negedge clk_i);
    cmd_valid_i = 1'b0;
    lat = 1; got = 1'b0; rdata = '0; err = 1'b0; req_at_rsp = 1'b0;
    while (lat < 300) begin
      if (rsp_valid_o) begin
        got = 1'b1; rdata = rsp_rdata_o; err = rsp_err_o; req_at_rsp = data_req_o;
        break;
      end
      @(negedge clk_i);
      lat++;
    end
    check_eq("rsp_seen", 32'(got), 32'd1);
    check_eq("req_low_at_rsp", 32'(req_at_rsp), 32'd0);
    @(negedge clk_i);
    check_eq("rsp_pulse_one_cycle", 32'(rsp_valid_o), 32'd0);
    check_eq("ready_after_rsp", 32'(cmd_ready_o), 32'd1);
    if (size == 2'b11 || exp_fail) begin
      check_eq("fail_err", 32'(err), 32'd1);
      check_eq("fail_rdata", rdata, 32'd0);
      if (size == 2'b11) check_eq("illegal_no_req", req_cycles, 32'd0);
    end else begin
      n = 1 << size; off = int'(addr[1:0]); base = {addr[31:2], 2'b00};
      parts = (off + n + 3) / 4;
      check_eq("part_count", q_addr.size(), parts);
      for (int k = 0; k < parts; k++) begin
        if (k < q_addr.size()) begin
          exp_be = '0; exp_w = '0; mask = '0;
          for (int j = 0; j < 4; j++) begin
            g = 4*k + j - off;
            if (g >= 0 && g < n) begin
              exp_be[j] = 1'b1;
              exp_w[8*j +: 8] = wdata[8*g +: 8];
              mask[8*j +: 8] = 8'hFF;
            end
          end
          check_eq("part_addr", q_addr[k], base + 32'(4*k));
          check_eq("part_be", 32'(q_be[k]), 32'(exp_be));
          check_eq("part_we", 32'(q_we[k]), 32'(we));
          if (we) check_eq("part_wdata_lanes", q_wdata[k] & mask, exp_w);
        end
      end
      exp_rd = '0;
      if (we) begin
        for (int b = 0; b < n; b++) refm[addr + 32'(b)] = wdata[8*b +: 8];
      end else begin
        for (int b = 0; b < n; b++) exp_rd[8*b +: 8] = ref_byte(addr + 32'(b));
        if (sgn && n < 4 && exp_rd[8*n-1]) exp_rd = exp_rd | (32'hFFFF_FFFF << (8*n));
      end
      check_eq("rsp_err", 32'(err), 32'd0);
      check_eq("rsp_rdata", rdata, exp_rd);
    end
  endtask

  initial begin
    bit [31:0] rd;
    int        lat, pulses;
    bit        r_we;
    bit [1:0]  r_size;
    bit [31:0] r_addr;
    rst_ni = 1'b0; cmd_valid_i = 1'b0; cmd_we_i = 1'b0; cmd_size_i = 2'b00;
    cmd_signed_i = 1'b0; cmd_addr_i = '0; cmd_wdata_i = '0;
    repeat (3) @(negedge clk_i);
    check_eq("rst_ready", 32'(cmd_ready_o), 32'd1);
    check_eq("rst_req", 32'(data_req_o), 32'd0);
    check_eq("rst_we", 32'(data_we_o), 32'd0);
    check_eq("rst_be", 32'(data_be_o), 32'd0);
    check_eq("rst_addr", data_addr_o, 32'd0);
    check_eq("rst_wdata", data_wdata_o, 32'd0);
    check_eq("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
    check_eq("rst_rsp_rdata", rsp_rdata_o, 32'd0);
    check_eq("rst_rsp_err", 32'(rsp_err_o), 32'd0);
    rst_ni = 1'b1;
    zero_wait = 1'b1; gnt_wait = 0;

    run_check(1'b1, 2'b10, 1'b0, 32'h0001_0004, 32'hDEAD_BEEF, 1'b0, rd, lat);
    check_eq("aligned_store_lat", lat, 32'd2);
    run_check(1'b0, 2'b10, 1'b0, 32'h0001_0004, 32'h0, 1'b0, rd, lat);
    check_eq("aligned_load_data", rd, 32'hDEAD_BEEF);
    check_eq("aligned_load_lat", lat, 32'd3);

    run_check(1'b1, 2'b10, 1'b0, 32'h0001_0000, 32'h80FF_7F01, 1'b0, rd, lat);
    run_check(1'b0, 2'b00, 1'b1, 32'h0001_0003, 32'h0, 1'b0, rd, lat);
    check_eq("signed_byte", rd, 32'hFFFF_FF80);
    check_eq("signed_byte_be", (q_be.size() > 0) ? 32'(q_be[0]) : 32'hFFFF_FFFF, 32'h8);
    run_check(1'b0, 2'b00, 1'b0, 32'h0001_0003, 32'h0, 1'b0, rd, lat);
    check_eq("unsigned_byte", rd, 32'h0000_0080);

    run_check(1'b1, 2'b10, 1'b0, 32'h0001_0000, 32'h4433_2211, 1'b0, rd, lat);
    run_check(1'b1, 2'b10, 1'b0, 32'h0001_0004, 32'h8877_6655, 1'b0, rd, lat);
    run_check(1'b0, 2'b10, 1'b0, 32'h0001_0003, 32'h0, 1'b0, rd, lat);
    check_eq("misaligned_word", rd, 32'h7766_5544);
    check_eq("misaligned_lat", lat, 32'd5);

    run_check(1'b1, 2'b01, 1'b0, 32'h0001_0007, 32'h0000_ABCD, 1'b0, rd, lat);
    check_eq("half_store_p1_byte", (q_wdata.size() > 0) ? 32'(q_wdata[0][31:24]) : 32'hFFFF, 32'hCD);
    check_eq("half_store_p2_byte", (q_wdata.size() > 1) ? 32'(q_wdata[1][7:0]) : 32'hFFFF, 32'hAB);
    check_eq("half_store_p2_addr", (q_addr.size() > 1) ? q_addr[1] : 32'hFFFF_FFFF, 32'h0001_0008);
    run_check(1'b0, 2'b01, 1'b0, 32'h0001_0007, 32'h0, 1'b0, rd, lat);
    check_eq("half_readback", rd, 32'h0000_ABCD);

    run_check(1'b1, 2'b10, 1'b0, 32'hFFFF_FFFE, 32'h1234_5678, 1'b0, rd, lat);
    run_check(1'b0, 2'b10, 1'b0, 32'hFFFF_FFFE, 32'h0, 1'b0, rd, lat);
    check_eq("wrap_readback", rd, 32'h1234_5678);

    err_next = 1'b1;
    run_check(1'b0, 2'b10, 1'b0, 32'h0001_0001, 32'h0, 1'b1, rd, lat);
    check_eq("err_skips_part2", q_addr.size(), 32'd1);

    block_gnt = 1'b1;
    run_check(1'b0, 2'b10, 1'b0, 32'h0001_0000, 32'h0, 1'b1, rd, lat);
    check_eq("timeout_req_cycles", req_cycles, TO);
    block_gnt = 1'b0;

    run_check(1'b0, 2'b11, 1'b0, 32'h0001_0000, 32'h0, 1'b0, rd, lat);

    // Abort a load while it waits for its response.
    no_rsp = 1'b1;
    @(negedge clk_i);
    cmd_valid_i = 1'b1; cmd_we_i = 1'b0; cmd_size_i = 2'b10; cmd_addr_i = 32'h0001_0000;
    @(negedge clk_i);
    cmd_valid_i = 1'b0;
    @(negedge clk_i);
    check_eq("no_req_in_wait", 32'(data_req_o), 32'd0);
    check_eq("busy_in_wait", 32'(cmd_ready_o), 32'd0);
    rst_ni = 1'b0;
    #1;
    check_eq("midrst_ready", 32'(cmd_ready_o), 32'd1);
    check_eq("midrst_req", 32'(data_req_o), 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1; pend_rsp = 1'b0; no_rsp = 1'b0;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_i);
      if (rsp_valid_o) pulses++;
    end
    check_eq("midrst_no_rsp", pulses, 32'd0);
    run_check(1'b0, 2'b10, 1'b0, 32'h0001_0004, 32'h0, 1'b0, rd, lat);

    zero_wait = 1'b0;
    for (int i = 0; i < 150; i++) begin
      r_we   = 1'($urandom_range(0, 1));
      r_size = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      r_addr = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF8 + 32'($urandom_range(0, 7))
                                           : 32'h0001_0000 + 32'($urandom_range(0, 31));
      run_check(r_we, r_size, 1'($urandom_range(0, 1)), r_addr, $urandom, 1'b0, rd, lat);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
`default_nettype wire
